vga_raster_timing: RTL and testbench

Parametrised raster timing generator for the VGA path. It produces horizontal and vertical counters, sync, blank and letterbox-border flags, and content-relative glyph coordinates for any resolution and sync polarity. Sync and blank are also provided delayed by a configurable number of pixel clocks, so they stay aligned with a framebuffer/font lookup pipeline of arbitrary depth. It replaces fixed-640x480 sync logic and hand-built sync delay chains in the VGA controller.

---
 rtl/vga_raster_timing.sv | 136 +++++++++++++
 tb/tb_vga_raster_timing.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_raster_timing.sv
// Raster timing generator: pixel/line counters, registered sync/blank/border
// flags decoded from the next counter value, glyph coordinates one clock
// behind, and sync/blank copies delayed to match a lookup pipeline.
module vga_raster_timing #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int BORDER_TOP   = 40,
  parameter int CONTENT_ROWS = 400,
  parameter int ROW_SHIFT    = 1,
  parameter int PIPE_DELAY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       border,
  output logic [9:0] content_row,
  output logic [2:0] glyph_col,
  output logic [2:0] glyph_row,
  output logic       frame_start,
  output logic       line_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       blank_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits: an end bound can equal 1024 when a back porch is 0.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] BD_BEG = 11'(BORDER_TOP);
  localparam logic [10:0] BD_END = 11'(BORDER_TOP + CONTENT_ROWS);

  logic [9:0] col_nxt, row_nxt;
  logic       h_wrap, v_wrap;
  logic       hs_act_nxt, vs_act_nxt, blank_nxt, border_nxt;

  // Next counter values and the flags that describe them.
  always_comb begin
    h_wrap  = enable && (col == H_LAST);
    v_wrap  = h_wrap && (row == V_LAST);
    col_nxt = col;
    row_nxt = row;
    if (enable) col_nxt = h_wrap ? 10'd0 : col + 10'd1;
    if (h_wrap) row_nxt = v_wrap ? 10'd0 : row + 10'd1;
    hs_act_nxt = ({1'b0, col_nxt} >= HS_BEG) && ({1'b0, col_nxt} < HS_END);
    vs_act_nxt = ({1'b0, row_nxt} >= VS_BEG) && ({1'b0, row_nxt} < VS_END);
    blank_nxt  = ({1'b0, col_nxt} >= H_ACT) || ({1'b0, row_nxt} >= V_ACT);
    border_nxt = !blank_nxt &&
                 (({1'b0, row_nxt} < BD_BEG) || ({1'b0, row_nxt} >= BD_END));
  end

  // Counters and registered flags; start pulses only on an enabled wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      hsync       <= !HSYNC_POL;
      vsync       <= !VSYNC_POL;
      blank       <= 1'b0;
      border      <= (BORDER_TOP > 0);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      col         <= col_nxt;
      row         <= row_nxt;
      hsync       <= hs_act_nxt ? HSYNC_POL : !HSYNC_POL;
      vsync       <= vs_act_nxt ? VSYNC_POL : !VSYNC_POL;
      blank       <= blank_nxt;
      border      <= border_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

  // Wraps modulo 1024, so rows above the content window read as large values.
  assign content_row = row - 10'(BORDER_TOP);

  // Glyph coordinates trail the counters by one clock for the font ROM address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_col <= '0;
      glyph_row <= '0;
    end else begin
      glyph_col <= col[2:0];
      glyph_row <= 3'(content_row >> ROW_SHIFT);
    end
  end

  // Delay line runs regardless of enable; bit 0 is newest, MSB is the output.
  if (PIPE_DELAY == 0) begin : g_nodly
    assign hsync_d = hsync;
    assign vsync_d = vsync;
    assign blank_d = blank;
  end else begin : g_dly
    logic [PIPE_DELAY-1:0] hs_sr, vs_sr, bl_sr;

    // Shift register loads inactive levels on reset so no stale sync escapes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hs_sr <= {PIPE_DELAY{!HSYNC_POL}};
        vs_sr <= {PIPE_DELAY{!VSYNC_POL}};
        bl_sr <= {PIPE_DELAY{1'b1}};
      end else begin
        hs_sr <= PIPE_DELAY'({hs_sr, hsync});
        vs_sr <= PIPE_DELAY'({vs_sr, vsync});
        bl_sr <= PIPE_DELAY'({bl_sr, blank});
      end
    end

    assign hsync_d = hs_sr[PIPE_DELAY-1];
    assign vsync_d = vs_sr[PIPE_DELAY-1];
    assign blank_d = bl_sr[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_raster_timing.sv
// Bench: one default-geometry instance for the 640x480 line checks, plus
// three small-geometry instances (delay 2/0/5, one with active-high syncs)
// checked every clock against a frame-position model through a scoreboard.
module tb_vga_raster_timing;

  // Small geometry: H_TOTAL = 25, V_TOTAL = 19, frame = 475 clocks.
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int BT = 3, CR = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [2:0][3:0] DLYS = {4'd5, 4'd0, 4'd2};
  localparam logic [2:0]      POLS = 3'b010;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1;
  logic reset_def = 1'b1, enable_def = 1'b1;

  always #5 clk = ~clk;

  // Default-parameter instance
  logic [9:0] d_col, d_row, d_cr;
  logic       d_hs, d_vs, d_bl, d_bd, d_fs, d_ls, d_hsd, d_vsd, d_bld;
  logic [2:0] d_gc, d_gr;

  vga_raster_timing u_def (
    .clk(clk), .reset(reset_def), .enable(enable_def),
    .col(d_col), .row(d_row), .hsync(d_hs), .vsync(d_vs), .blank(d_bl),
    .border(d_bd), .content_row(d_cr), .glyph_col(d_gc), .glyph_row(d_gr),
    .frame_start(d_fs), .line_start(d_ls),
    .hsync_d(d_hsd), .vsync_d(d_vsd), .blank_d(d_bld)
  );

  // Small-geometry instances
  logic [9:0] s_col [3], s_row [3], s_cr [3];
  logic [2:0] s_gc [3], s_gr [3];
  logic       s_hs [3], s_vs [3], s_bl [3], s_bd [3], s_fs [3], s_ls [3];
  logic       s_hsd [3], s_vsd [3], s_bld [3];

  for (genvar k = 0; k < 3; k++) begin : g_small
    vga_raster_timing #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(POLS[k]), .VSYNC_POL(POLS[k]),
      .BORDER_TOP(BT), .CONTENT_ROWS(CR), .ROW_SHIFT(1),
      .PIPE_DELAY(int'(DLYS[k]))
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable),
      .col(s_col[k]), .row(s_row[k]), .hsync(s_hs[k]), .vsync(s_vs[k]),
      .blank(s_bl[k]), .border(s_bd[k]), .content_row(s_cr[k]),
      .glyph_col(s_gc[k]), .glyph_row(s_gr[k]),
      .frame_start(s_fs[k]), .line_start(s_ls[k]),
      .hsync_d(s_hsd[k]), .vsync_d(s_vsd[k]), .blank_d(s_bld[k])
    );
  end

  typedef struct packed {
    logic [9:0] col, row, cr;
    logic [2:0] gc, gr;
    logic       hs, vs, bl, bd, fs, ls, hsd, vsd, bld;
  } obs_t;

  typedef struct {
    logic rst;
    logic en;
    int   n;
    int   c;
    int   r;
  } vec_t;

  int   vec_cnt = 0;
  int   miss_cnt = 0;
  obs_t sb_q[$];

  // Model state: position in frame plus the registered side values.
  int         t;
  logic       m_fs, m_ls;
  logic [2:0] m_gc, m_gr;
  logic       hh [3][8];
  logic       vh [3][8];
  logic       bh [3][8];

  function automatic logic lvl(logic act, logic pol);
    return act ? pol : !pol;
  endfunction

  function automatic int mcol();
    return t % HT;
  endfunction

  function automatic int mrow();
    return t / HT;
  endfunction

  function automatic logic h_act(int c);
    return (c >= HA + HF) && (c < HA + HF + HS);
  endfunction

  function automatic logic v_act(int r);
    return (r >= VA + VF) && (r < VA + VF + VS);
  endfunction

  function automatic logic m_blank(int c, int r);
    return (c >= HA) || (r >= VA);
  endfunction

  task automatic model_reset();
    t = 0; m_fs = 1'b0; m_ls = 1'b0; m_gc = '0; m_gr = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        hh[k][i] = !POLS[k];
        vh[k][i] = !POLS[k];
        bh[k][i] = 1'b1;
      end
  endtask

  task automatic model_edge();
    int c, r;
    logic [9:0] cr;
    if (reset) begin
      model_reset();
    end else begin
      c = mcol(); r = mrow();
      for (int k = 0; k < 3; k++) begin
        for (int i = 7; i > 0; i--) begin
          hh[k][i] = hh[k][i-1]; vh[k][i] = vh[k][i-1]; bh[k][i] = bh[k][i-1];
        end
        hh[k][0] = lvl(h_act(c), POLS[k]);
        vh[k][0] = lvl(v_act(r), POLS[k]);
        bh[k][0] = m_blank(c, r);
      end
      m_gc = 3'(c);
      cr   = 10'(r) - 10'(BT);
      m_gr = 3'(cr >> 1);
      if (enable) begin
        t    = (t + 1) % FT;
        m_ls = (t % HT) == 0;
        m_fs = (t == 0);
      end else begin
        m_ls = 1'b0;
        m_fs = 1'b0;
      end
    end
  endtask

  function automatic obs_t model_obs(int k);
    obs_t o;
    int c, r, d;
    c = mcol(); r = mrow(); d = int'(DLYS[k]);
    o.col = 10'(c);
    o.row = 10'(r);
    o.cr  = 10'(r) - 10'(BT);
    o.gc  = m_gc;
    o.gr  = m_gr;
    o.hs  = lvl(h_act(c), POLS[k]);
    o.vs  = lvl(v_act(r), POLS[k]);
    o.bl  = m_blank(c, r);
    o.bd  = !o.bl && (r < BT || r >= BT + CR);
    o.fs  = m_fs;
    o.ls  = m_ls;
    o.hsd = (d == 0) ? o.hs : hh[k][d-1];
    o.vsd = (d == 0) ? o.vs : vh[k][d-1];
    o.bld = (d == 0) ? o.bl : bh[k][d-1];
    return o;
  endfunction

  function automatic obs_t dut_obs(int k);
    obs_t o;
    o.col = s_col[k]; o.row = s_row[k]; o.cr = s_cr[k];
    o.gc  = s_gc[k];  o.gr  = s_gr[k];
    o.hs  = s_hs[k];  o.vs  = s_vs[k];  o.bl = s_bl[k]; o.bd = s_bd[k];
    o.fs  = s_fs[k];  o.ls  = s_ls[k];
    o.hsd = s_hsd[k]; o.vsd = s_vsd[k]; o.bld = s_bld[k];
    return o;
  endfunction

  task automatic push_exp();
    for (int k = 0; k < 3; k++) sb_q.push_back(model_obs(k));
  endtask

  task automatic pop_check(string tag);
    obs_t e, a;
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      a = dut_obs(k);
      vec_cnt++;
      if (a !== e) begin
        miss_cnt++;
        $display("FAIL %s dut%0d t=%0d got %h want %h", tag, k, t, a, e);
      end
    end
  endtask

  // One clock of the small instances: model advances, expectation queued, DUT compared.
  task automatic tick();
    @(posedge clk);
    model_edge();
    push_exp();
    #1;
    pop_check("cycle");
  endtask

  task automatic chk(string name, int act, int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int def_hs(int j);
    int c;
    c = (j < 0) ? 0 : j % 800;
    return int'(!(c >= 656 && c < 752));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   low_cnt, n;
    logic seen;

    tbl[0]  = '{1'b1, 1'b1, 3,   0,  0};
    tbl[1]  = '{1'b0, 1'b1, 1,   1,  0};
    tbl[2]  = '{1'b0, 1'b1, 24,  0,  1};
    tbl[3]  = '{1'b0, 1'b0, 5,   0,  1};
    tbl[4]  = '{1'b0, 1'b1, 7,   7,  1};
    tbl[5]  = '{1'b0, 1'b0, 3,   7,  1};
    tbl[6]  = '{1'b0, 1'b1, 443, 0,  0};
    tbl[7]  = '{1'b0, 1'b1, 300, 0,  12};
    tbl[8]  = '{1'b0, 1'b1, 95,  20, 15};
    tbl[9]  = '{1'b1, 1'b1, 2,   0,  0};
    tbl[10] = '{1'b0, 1'b1, 475, 0,  0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Default instance: reset values
    chk("def_rst_col",    int'(d_col), 0);
    chk("def_rst_row",    int'(d_row), 0);
    chk("def_rst_hsync",  int'(d_hs), 1);
    chk("def_rst_vsync",  int'(d_vs), 1);
    chk("def_rst_blank",  int'(d_bl), 0);
    chk("def_rst_border", int'(d_bd), 1);
    chk("def_rst_fs",     int'(d_fs), 0);
    chk("def_rst_ls",     int'(d_ls), 0);
    chk("def_rst_hsd",    int'(d_hsd), 1);
    chk("def_rst_vsd",    int'(d_vsd), 1);
    chk("def_rst_bld",    int'(d_bld), 1);
    chk("def_rst_gc",     int'(d_gc), 0);

    // Default instance: one full line, hsync low exactly on cols 656..751
    reset_def = 1'b0;
    low_cnt = 0;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clk);
      #1;
      chk("def_col",        int'(d_col), i % 800);
      chk("def_hsync",      int'(d_hs), def_hs(i));
      chk("def_blank",      int'(d_bl), int'((i % 800) >= 640));
      chk("def_line_start", int'(d_ls), int'((i % 800) == 0));
      chk("def_glyph_col",  int'(d_gc), (i - 1) % 8);
      chk("def_hsync_d",    int'(d_hsd), def_hs(i - 2));
      if (!d_hs) low_cnt++;
    end
    chk("def_hsync_width", low_cnt, 96);
    chk("def_row_after_line", int'(d_row), 1);

    // Default instance: enable low for 37 clocks at col 300
    repeat (300) @(posedge clk);
    #1;
    chk("pause_col", int'(d_col), 300);
    enable_def = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      chk("hold_col", int'(d_col), 300);
      chk("hold_ls",  int'(d_ls), 0);
    end
    enable_def = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_col", int'(d_col), 301);

    // Small instances: table of reset/enable runs with position checkpoints
    for (int i = 0; i < 11; i++) begin
      reset  = tbl[i].rst;
      enable = tbl[i].en;
      repeat (tbl[i].n) tick();
      chk("tbl_col", int'(s_col[0]), tbl[i].c);
      chk("tbl_row", int'(s_row[0]), tbl[i].r);
    end

    // Asynchronous reset inside vsync, away from any clock edge
    repeat (395) tick();
    chk("pre_rst_col", int'(s_col[0]), 20);
    chk("pre_rst_row", int'(s_row[0]), 15);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp();
    pop_check("async_reset");
    tick();
    reset = 1'b0;

    // First frame_start after release, then one full frame period
    n = 0; seen = 1'b0;
    while (!seen && n < 600) begin
      tick();
      n++;
      if (s_fs[0]) seen = 1'b1;
    end
    chk("first_frame_start", n, FT);
    n = 0; seen = 1'b0;
    while (!seen && n < 600) begin
      tick();
      n++;
      if (s_fs[0]) seen = 1'b1;
    end
    chk("frame_period", n, FT);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
